stopwatch_fsm_core: RTL and testbench

//  Stopwatch control and timekeeping stage. Sits directly downstream of the
//  1 kHz divided clock. Samples the divided clock as data in the clk_in

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_fsm_core_bcd_digit.sv | 36 +++
 rtl/stopwatch_fsm_core.sv | 149 ++++++++++++++
 tb/tb_stopwatch_fsm_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: state encoding, BCD digit geometry and display layout.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_LAP     = 2'b10,
    ST_PAUSED  = 2'b11
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 6;
  localparam int DISP_W     = DIGIT_W * NUM_DIGITS;
  localparam int MOD_DEC    = 10;
  localparam int MOD_SEX    = 6;

  localparam int HUND1_LSB  = 0;
  localparam int HUND10_LSB = 4;
  localparam int SEC1_LSB   = 8;
  localparam int SEC10_LSB  = 12;
  localparam int MIN1_LSB   = 16;
  localparam int MIN10_LSB  = 20;

  // Digit 3 (sec10) counts 0-5; every other digit is decimal.
  function automatic int digit_modulus(input int idx);
    return (idx == 3) ? MOD_SEX : MOD_DEC;
  endfunction

endpackage

// File: rtl/stopwatch_fsm_core_bcd_digit.sv
// Modulo-N BCD digit: registered value, clr beats inc_in, carry_out is combinational.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc_in,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out
);

  logic [DIGIT_W-1:0] value_q, value_d;
  logic               at_max;

  assign at_max    = (value_q == DIGIT_W'(MODULUS - 1));
  assign carry_out = inc_in & at_max;
  assign value     = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc_in) begin
      value_d = at_max ? '0 : value_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

endmodule

// File: rtl/stopwatch_fsm_core.sv
// Stopwatch control: samples the divided clock as data for a 1 ms tick, runs the
// IDLE/RUNNING/LAP/PAUSED FSM and keeps BCD MM:SS.hh with a frozen lap display.
module stopwatch_fsm_core
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_HUND = 10,
  parameter int MAX_MIN        = 59
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              tick_clk,
  input  logic              btn_start_stop,
  input  logic              btn_lap,
  input  logic              btn_clear,
  output logic [DISP_W-1:0] disp_bcd,
  output logic [1:0]        state,
  output logic              running,
  output logic              rollover
);

  logic tick_sync1_q, tick_sync2_q, tick_hist_q;
  logic ss_hist_q, lap_hist_q, clr_hist_q;
  logic tick_pulse, ss_evt, lap_evt, clr_evt;

  state_t             state_q, state_d;
  logic [DISP_W-1:0]  lap_q, lap_d;
  logic [DISP_W-1:0]  disp_q, disp_d;
  logic               running_q, running_d;
  logic               rollover_q, rollover_d;
  logic [15:0]        presc_q, presc_d;

  logic [DISP_W-1:0]     count_live;
  logic [NUM_DIGITS-1:0] dig_inc, dig_cy;
  logic                  count_en, presc_wrap, hund_step, clear_all;
  logic                  min_at_max, wrap_evt, dig_clr;

  assign tick_pulse = tick_sync2_q & ~tick_hist_q;

  // start_stop > lap > clear when presses land on the same cycle.
  assign ss_evt  = btn_start_stop & ~ss_hist_q;
  assign lap_evt = btn_lap & ~lap_hist_q & ~ss_evt;
  assign clr_evt = btn_clear & ~clr_hist_q & ~ss_evt & ~(btn_lap & ~lap_hist_q);

  assign count_en   = tick_pulse & ((state_q == ST_RUNNING) | (state_q == ST_LAP));
  assign presc_wrap = (presc_q == 16'(TICKS_PER_HUND - 1));
  assign hund_step  = count_en & presc_wrap;

  assign dig_inc = {dig_cy[NUM_DIGITS-2:0], hund_step};

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_counter #(
      .MODULUS(digit_modulus(i))
    ) u_digit (
      .clk_in   (clk_in),
      .reset    (reset),
      .clr      (dig_clr),
      .inc_in   (dig_inc[i]),
      .value    (count_live[i*DIGIT_W +: DIGIT_W]),
      .carry_out(dig_cy[i])
    );
  end

  // The minute pair wraps at MAX_MIN:59.99 rather than at its natural 99.
  assign min_at_max = (count_live[MIN10_LSB +: DIGIT_W] == DIGIT_W'(MAX_MIN / 10)) &
                      (count_live[MIN1_LSB  +: DIGIT_W] == DIGIT_W'(MAX_MIN % 10));
  assign wrap_evt   = (dig_cy[3] & min_at_max) | dig_cy[NUM_DIGITS-1];
  assign dig_clr    = clear_all | wrap_evt;

  always_comb begin
    state_d   = state_q;
    lap_d     = lap_q;
    clear_all = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_evt) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (ss_evt) begin
          state_d = ST_PAUSED;
        end else if (lap_evt) begin
          state_d = ST_LAP;
          lap_d   = count_live;
        end
      end
      ST_LAP: begin
        if (ss_evt) begin
          state_d = ST_PAUSED;
          lap_d   = '0;
        end else if (lap_evt) begin
          lap_d = count_live;
        end
      end
      ST_PAUSED: begin
        if (ss_evt) begin
          state_d = ST_RUNNING;
        end else if (clr_evt) begin
          state_d   = ST_IDLE;
          clear_all = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    if (clear_all)     presc_d = '0;
    else if (count_en) presc_d = presc_wrap ? '0 : presc_q + 16'd1;
  end

  assign disp_d     = (state_q == ST_LAP) ? lap_q : count_live;
  assign running_d  = (state_d == ST_RUNNING) | (state_d == ST_LAP);
  assign rollover_d = wrap_evt;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tick_sync1_q <= 1'b0;
      tick_sync2_q <= 1'b0;
      tick_hist_q  <= 1'b0;
      ss_hist_q    <= 1'b0;
      lap_hist_q   <= 1'b0;
      clr_hist_q   <= 1'b0;
      state_q      <= ST_IDLE;
      lap_q        <= '0;
      disp_q       <= '0;
      running_q    <= 1'b0;
      rollover_q   <= 1'b0;
      presc_q      <= '0;
    end else begin
      tick_sync1_q <= tick_clk;
      tick_sync2_q <= tick_sync1_q;
      tick_hist_q  <= tick_sync2_q;
      ss_hist_q    <= btn_start_stop;
      lap_hist_q   <= btn_lap;
      clr_hist_q   <= btn_clear;
      state_q      <= state_d;
      lap_q        <= lap_d;
      disp_q       <= disp_d;
      running_q    <= running_d;
      rollover_q   <= rollover_d;
      presc_q      <= presc_d;
    end
  end

  assign disp_bcd = disp_q;
  assign state    = state_q;
  assign running  = running_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_fsm_core.sv
// Directed bench for stopwatch_fsm_core; the minute range is shortened so the wrap is reachable.
module tb_stopwatch_fsm_core;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        tick_clk = 1'b0;
  logic        btn_start_stop = 1'b0;
  logic        btn_lap = 1'b0;
  logic        btn_clear = 1'b0;
  logic [23:0] disp_bcd;
  logic [1:0]  state;
  logic        running;
  logic        rollover;

  int checks = 0;
  int errors = 0;

  stopwatch_fsm_core #(
    .TICKS_PER_HUND(1),
    .MAX_MIN       (1)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .tick_clk      (tick_clk),
    .btn_start_stop(btn_start_stop),
    .btn_lap       (btn_lap),
    .btn_clear     (btn_clear),
    .disp_bcd      (disp_bcd),
    .state         (state),
    .running       (running),
    .rollover      (rollover)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_clk = 1'b1;
      cyc(4);
      tick_clk = 1'b0;
      cyc(4);
    end
  endtask

  task automatic fast_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_clk = 1'b1;
      cyc(2);
      tick_clk = 1'b0;
      cyc(2);
    end
  endtask

  task automatic press(input logic ss, input logic lp, input logic cl);
    btn_start_stop = ss;
    btn_lap        = lp;
    btn_clear      = cl;
    cyc(1);
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (disp_bcd !== 24'h000000) begin errors++; $display("FAIL reset_disp got %h want 000000", disp_bcd); end
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state); end
    checks++;
    if ({running, rollover} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {running, rollover}); end
  endtask

  task automatic test_run_count();
    press(1'b1, 1'b0, 1'b0);
    ticks(25);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL run_state got %b want 01", state); end
    checks++;
    if (disp_bcd !== 24'h000025) begin errors++; $display("FAIL run_disp got %h want 000025", disp_bcd); end
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL run_running got %b want 1", running); end
  endtask

  task automatic test_lap();
    apply_reset();
    press(1'b1, 1'b0, 1'b0);
    ticks(12);
    press(1'b0, 1'b1, 1'b0);
    ticks(30);
    checks++;
    if (disp_bcd !== 24'h000012) begin errors++; $display("FAIL lap_hold got %h want 000012", disp_bcd); end
    checks++;
    if (state !== 2'b10 || running !== 1'b1) begin errors++; $display("FAIL lap_state got %b/%b want 10/1", state, running); end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'b11 || running !== 1'b0) begin errors++; $display("FAIL lap_pause got %b/%b want 11/0", state, running); end
    checks++;
    if (disp_bcd !== 24'h000042) begin errors++; $display("FAIL lap_release got %h want 000042", disp_bcd); end
  endtask

  task automatic test_priority();
    press(1'b1, 1'b0, 1'b0);
    ticks(265);
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'b11 || disp_bcd !== 24'h000307) begin errors++; $display("FAIL prio_setup got %b %h want 11 000307", state, disp_bcd); end
    press(1'b1, 1'b0, 1'b1);
    checks++;
    if (state !== 2'b01 || disp_bcd !== 24'h000307) begin errors++; $display("FAIL prio_ss_wins got %b %h want 01 000307", state, disp_bcd); end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 2'b01 || disp_bcd !== 24'h000307) begin errors++; $display("FAIL prio_clear_ignored got %b %h want 01 000307", state, disp_bcd); end
  endtask

  task automatic test_clear_idle();
    press(1'b1, 1'b0, 1'b0);
    ticks(5);
    checks++;
    if (state !== 2'b11 || disp_bcd !== 24'h000307) begin errors++; $display("FAIL paused_hold got %b %h want 11 000307", state, disp_bcd); end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 2'b00 || disp_bcd !== 24'h000000) begin errors++; $display("FAIL clear_idle got %b %h want 00 000000", state, disp_bcd); end
    ticks(3);
    checks++;
    if (disp_bcd !== 24'h000000) begin errors++; $display("FAIL idle_hold got %h want 000000", disp_bcd); end
  endtask

  task automatic test_reset_midcount();
    press(1'b1, 1'b0, 1'b0);
    ticks(750);
    checks++;
    if (disp_bcd !== 24'h000750) begin errors++; $display("FAIL mid_setup got %h want 000750", disp_bcd); end
    reset = 1'b1;
    #1;
    checks++;
    if (disp_bcd !== 24'h000000 || state !== 2'b00 || running !== 1'b0 || rollover !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %h %b %b %b want all zero", disp_bcd, state, running, rollover);
    end
    cyc(2);
    reset = 1'b0;
    cyc(1);
    ticks(5);
    checks++;
    if (disp_bcd !== 24'h000000 || state !== 2'b00) begin errors++; $display("FAIL post_reset_idle got %b %h want 00 000000", state, disp_bcd); end
    press(1'b1, 1'b0, 1'b0);
    ticks(1);
    checks++;
    if (disp_bcd !== 24'h000001) begin errors++; $display("FAIL post_reset_start got %h want 000001", disp_bcd); end
  endtask

  task automatic test_carry_rollover();
    int hi_cycles;
    apply_reset();
    press(1'b1, 1'b0, 1'b0);
    fast_ticks(5999);
    checks++;
    if (disp_bcd !== 24'h005999) begin errors++; $display("FAIL carry_setup got %h want 005999", disp_bcd); end
    fast_ticks(1);
    checks++;
    if (disp_bcd !== 24'h010000) begin errors++; $display("FAIL carry_minute got %h want 010000", disp_bcd); end
    fast_ticks(5999);
    checks++;
    if (disp_bcd !== 24'h015999) begin errors++; $display("FAIL wrap_setup got %h want 015999", disp_bcd); end
    hi_cycles = 0;
    tick_clk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (rollover === 1'b1) hi_cycles++;
    end
    tick_clk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (rollover === 1'b1) hi_cycles++;
    end
    checks++;
    if (hi_cycles != 1) begin errors++; $display("FAIL rollover_pulse got %0d cycles want 1", hi_cycles); end
    checks++;
    if (disp_bcd !== 24'h000000 || state !== 2'b01) begin errors++; $display("FAIL wrap_zero got %b %h want 01 000000", state, disp_bcd); end
    fast_ticks(1);
    checks++;
    if (disp_bcd !== 24'h000001) begin errors++; $display("FAIL wrap_continue got %h want 000001", disp_bcd); end
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_lap();
    test_priority();
    test_clear_idle();
    test_reset_midcount();
    test_carry_rollover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
